pwm_cmd_ctrl: RTL and testbench

Byte-command controller that sits between the UART receiver/transmitter and the bank of PWM channel blocks. It decodes received bytes into channel-select, duty-write, commit and readback commands, and holds a shadow and an active duty register per channel. Shadow values are applied to the active registers glitch-free on a PWM period boundary. Every received byte produces exactly one response byte through a handshaked transmit path.

---
 rtl/pwm_cmd_pkg.sv | 24 ++
 rtl/pwm_resp_tx.sv | 93 +++++++++
 rtl/pwm_cmd_ctrl.sv | 125 ++++++++++++
 tb/tb_pwm_cmd_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_cmd_pkg.sv
// Shared definitions for the PWM byte-command controller: command byte
// codes, the error response, the transmit handshake states and the 7-to-8
// bit duty expansion used by the duty-write command.
package pwm_cmd_pkg;

  localparam logic [7:0] CMD_SEL_BASE = 8'h80;
  localparam logic [7:0] CMD_COMMIT   = 8'hFE;
  localparam logic [7:0] CMD_READ     = 8'hFF;
  localparam logic [7:0] RESP_ERR     = 8'h3F;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_PEND,
    TX_SENT,
    TX_BUSY
  } tx_state_e;

  // Replicating the top payload bit into the LSB maps 0x00->0x00 and
  // 0x7F->0xFF, so both ends of the duty range are reachable.
  function automatic logic [7:0] expand_duty(input logic [6:0] d);
    return {d, d[6]};
  endfunction

endpackage

// File: rtl/pwm_resp_tx.sv
// Single-entry response buffer and UART transmit handshake.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   resp_valid_i    one-cycle strobe: resp_byte_i is a new response
//   resp_byte_i     response byte to queue
//   tx_busy_i       UART transmitter busy
//   tx_start_o      one-cycle strobe: UART should take tx_byte_o
//   tx_byte_o       byte offered to the UART
//   ovr_err_o       sticky: an unlaunched response was overwritten
module pwm_resp_tx
  import pwm_cmd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       resp_valid_i,
  input  logic [7:0] resp_byte_i,
  input  logic       tx_busy_i,
  output logic       tx_start_o,
  output logic [7:0] tx_byte_o,
  output logic       ovr_err_o
);

  tx_state_e  state_q, state_d;
  logic       pend_vld_q, pend_vld_d;
  logic [7:0] pend_byte_q, pend_byte_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       ovr_q, ovr_d;
  logic       sent_wait_q, sent_wait_d;
  logic       launch;

  always_comb begin
    state_d     = state_q;
    pend_vld_d  = pend_vld_q;
    pend_byte_d = pend_byte_q;
    tx_byte_d   = tx_byte_q;
    ovr_d       = ovr_q;
    sent_wait_d = sent_wait_q;
    launch      = (state_q == TX_PEND) && !tx_busy_i;

    unique case (state_q)
      TX_IDLE: if (pend_vld_q) state_d = TX_PEND;
      TX_PEND: begin
        if (launch) begin
          state_d     = TX_SENT;
          tx_byte_d   = pend_byte_q;
          sent_wait_d = 1'b0;
        end
      end
      TX_SENT: begin
        // No busy within two cycles means the UART latched the byte at once.
        if (tx_busy_i)        state_d = TX_BUSY;
        else if (sent_wait_q) state_d = TX_IDLE;
        else                  sent_wait_d = 1'b1;
      end
      TX_BUSY: if (!tx_busy_i) state_d = pend_vld_q ? TX_PEND : TX_IDLE;
      default: state_d = TX_IDLE;
    endcase

    if (launch) pend_vld_d = 1'b0;
    // A response arriving in the launch cycle queues behind the launched
    // byte; otherwise it replaces any unlaunched one.
    if (resp_valid_i) begin
      pend_vld_d  = 1'b1;
      pend_byte_d = resp_byte_i;
      if (pend_vld_q && !launch) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= TX_IDLE;
      pend_vld_q  <= 1'b0;
      pend_byte_q <= '0;
      tx_byte_q   <= '0;
      ovr_q       <= 1'b0;
      sent_wait_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_vld_q  <= pend_vld_d;
      pend_byte_q <= pend_byte_d;
      tx_byte_q   <= tx_byte_d;
      ovr_q       <= ovr_d;
      sent_wait_q <= sent_wait_d;
    end
  end

  // The pending byte is shown while waiting to launch; from launch until
  // the next launch the latched copy holds it stable for the UART.
  assign tx_start_o = launch;
  assign tx_byte_o  = (state_q == TX_PEND) ? pend_byte_q : tx_byte_q;
  assign ovr_err_o  = ovr_q;

endmodule

// File: rtl/pwm_cmd_ctrl.sv
// Byte-command controller between the UART and the PWM channel bank.
// Decodes received bytes into select / duty-write / commit / readback,
// keeps shadow and active duty registers per channel, applies shadow to
// active on a PWM period boundary and returns one response per byte.
// Ports:
//   iCE_CLK, rst_n       clock, asynchronous active-low reset
//   rx_valid, rx_byte    received byte strobe and data
//   period_tick          PWM counter wrap strobe
//   tx_busy              UART transmitter busy
//   tx_start, tx_byte    response handshake to the UART
//   duty_out             active duty values, channel i at [8i+7:8i]
//   update               strobe when active registers load
//   cmd_err, ovr_err     sticky illegal-command / response-overrun flags
module pwm_cmd_ctrl
  import pwm_cmd_pkg::*;
#(
  parameter int unsigned NCHAN  = 4,
  parameter int unsigned DUTY_W = 8
) (
  input  logic                    iCE_CLK,
  input  logic                    rst_n,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_byte,
  input  logic                    period_tick,
  input  logic                    tx_busy,
  output logic                    tx_start,
  output logic [7:0]              tx_byte,
  output logic [NCHAN*DUTY_W-1:0] duty_out,
  output logic                    update,
  output logic                    cmd_err,
  output logic                    ovr_err
);

  localparam int unsigned SEL_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  logic [DUTY_W-1:0] shadow_q [NCHAN];
  logic [DUTY_W-1:0] shadow_d [NCHAN];
  logic [DUTY_W-1:0] active_q [NCHAN];
  logic [DUTY_W-1:0] active_d [NCHAN];
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              commit_pend_q, commit_pend_d;
  logic              update_q;
  logic              cmd_err_q, cmd_err_d;
  logic              apply;
  logic [7:0]        sel_off;
  logic              is_sel;
  logic [7:0]        resp_byte;

  assign sel_off = rx_byte - CMD_SEL_BASE;
  assign is_sel  = rx_byte[7] && (sel_off < 8'(NCHAN));

  always_comb begin
    shadow_d      = shadow_q;
    active_d      = active_q;
    sel_d         = sel_q;
    commit_pend_d = commit_pend_q;
    cmd_err_d     = cmd_err_q;
    resp_byte     = rx_byte;
    apply         = period_tick && commit_pend_q;

    // Apply copies the registered shadow, so a same-cycle duty write lands
    // only in shadow; a same-cycle commit re-arms for the next tick.
    if (apply) begin
      active_d      = shadow_q;
      commit_pend_d = 1'b0;
    end

    if (rx_valid) begin
      if (!rx_byte[7]) begin
        shadow_d[sel_q] = expand_duty(rx_byte[6:0]);
      end else if (is_sel) begin
        sel_d = sel_off[SEL_W-1:0];
      end else if (rx_byte == CMD_COMMIT) begin
        commit_pend_d = 1'b1;
      end else if (rx_byte == CMD_READ) begin
        resp_byte = active_q[sel_q];
      end else begin
        cmd_err_d = 1'b1;
        resp_byte = RESP_ERR;
      end
    end
  end

  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCHAN; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      sel_q         <= '0;
      commit_pend_q <= 1'b0;
      update_q      <= 1'b0;
      cmd_err_q     <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      sel_q         <= sel_d;
      commit_pend_q <= commit_pend_d;
      update_q      <= apply;
      cmd_err_q     <= cmd_err_d;
    end
  end

  always_comb begin
    duty_out = '0;
    for (int unsigned i = 0; i < NCHAN; i++) begin
      duty_out[i*DUTY_W +: DUTY_W] = active_q[i];
    end
  end

  assign update  = update_q;
  assign cmd_err = cmd_err_q;

  pwm_resp_tx u_resp_tx (
    .clk_i       (iCE_CLK),
    .rst_ni      (rst_n),
    .resp_valid_i(rx_valid),
    .resp_byte_i (resp_byte),
    .tx_busy_i   (tx_busy),
    .tx_start_o  (tx_start),
    .tx_byte_o   (tx_byte),
    .ovr_err_o   (ovr_err)
  );

endmodule

// File: tb/tb_pwm_cmd_ctrl.sv
// Self-checking bench for pwm_cmd_ctrl: table-driven command vectors,
// hand-written multi-cycle sequences, and a randomized run checked against
// an array-based behavioural model of the command rules.
module tb_pwm_cmd_ctrl;

  localparam int NCHAN = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             rx_valid;
  logic [7:0]       rx_byte;
  logic             period_tick;
  logic             tx_busy;
  logic             tx_start;
  logic [7:0]       tx_byte;
  logic [NCHAN*8-1:0] duty_out;
  logic             update;
  logic             cmd_err;
  logic             ovr_err;

  logic uart_busy = 1'b0;
  logic man_busy  = 1'b0;
  bit   uart_auto = 1'b0;
  assign tx_busy = uart_busy | man_busy;

  int tests = 0;
  int fails = 0;
  int starts = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  // behavioural model state
  int m_sh [NCHAN];
  int m_act[NCHAN];
  int m_sel;
  bit m_pend;
  bit m_cerr;

  always #5 clk = ~clk;

  pwm_cmd_ctrl #(.NCHAN(NCHAN), .DUTY_W(8)) dut (
    .iCE_CLK    (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .period_tick(period_tick),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_byte    (tx_byte),
    .duty_out   (duty_out),
    .update     (update),
    .cmd_err    (cmd_err),
    .ovr_err    (ovr_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // UART side: records every launched byte; in auto mode goes busy for a
  // random 0..3 cycles starting the cycle after tx_start.
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        starts++;
        got.push_back(tx_byte);
        chk("start_while_busy", 64'(tx_busy), 64'd0);
        if (uart_auto) begin
          d = $urandom_range(0, 3);
          @(posedge clk); #1;
          if (d > 0) begin
            uart_busy = 1'b1;
            repeat (d) @(posedge clk);
            #1 uart_busy = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic drive1(input logic rv, input logic [7:0] b, input logic t);
    rx_valid    = rv;
    rx_byte     = b;
    period_tick = t;
    @(posedge clk); #1;
    rx_valid    = 1'b0;
    period_tick = 1'b0;
  endtask

  task automatic wait_resp(input int n, output logic [7:0] b);
    int k = 0;
    while (got.size() <= n && k < 40) begin
      drive1(1'b0, 8'h00, 1'b0);
      k++;
    end
    chk("resp_arrived", 64'(got.size() > n), 64'd1);
    b = (got.size() > n) ? got[n] : 8'h00;
  endtask

  task automatic send(input logic [7:0] b, input logic [7:0] r_exp, input string nm);
    int n;
    logic [7:0] r;
    n = got.size();
    drive1(1'b1, b, 1'b0);
    wait_resp(n, r);
    chk(nm, 64'(r), 64'(r_exp));
  endtask

  task automatic do_reset();
    rx_valid = 1'b0; rx_byte = 8'h00; period_tick = 1'b0; man_busy = 1'b0;
    repeat (6) @(posedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    got.delete();
    exp_q.delete();
  endtask

  function automatic logic [63:0] model_duty();
    logic [63:0] r = '0;
    for (int i = 0; i < NCHAN; i++) r[i*8 +: 8] = 8'(m_act[i]);
    return r;
  endfunction

  // One cycle of the reference model, then drive the DUT and compare.
  task automatic mcycle(input logic rv, input logic [7:0] b, input logic t);
    int nsh[NCHAN];
    int bi;
    bit ap;
    int resp;
    bi   = int'(b);
    ap   = t && m_pend;
    nsh  = m_sh;
    resp = bi;
    if (rv) begin
      if (bi < 128)               nsh[m_sel] = (bi * 2 + bi / 64) % 256;
      else if (bi - 128 < NCHAN)  m_sel = bi - 128;
      else if (bi == 254)         ;
      else if (bi == 255)         resp = m_act[m_sel];
      else begin m_cerr = 1'b1; resp = 63; end
    end
    if (ap) begin
      m_act  = m_sh;
      m_pend = 1'b0;
    end
    if (rv && bi == 254) m_pend = 1'b1;
    m_sh = nsh;
    if (rv) exp_q.push_back(8'(resp));
    drive1(rv, b, t);
    chk("rand_duty", 64'(duty_out), model_duty());
    chk("rand_update", 64'(update), 64'(ap));
    chk("rand_cmd_err", 64'(cmd_err), 64'(m_cerr));
  endtask

  typedef struct {
    logic        rv;
    logic [7:0]  rb;
    logic        tick;
    logic [7:0]  resp;
    logic [31:0] duty;
    logic        upd;
    logic        cerr;
  } vec_t;

  vec_t vt[13];

  initial begin
    int n, s0;
    logic [7:0] r;
    logic [7:0] b;

    vt[0]  = '{1'b1, 8'h81, 1'b0, 8'h81, 32'h0000_0000, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 8'h40, 1'b0, 8'h40, 32'h0000_0000, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 8'hFE, 1'b0, 8'hFE, 32'h0000_0000, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 8'h00, 1'b1, 8'h00, 32'h0000_8100, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 8'h82, 1'b0, 8'h82, 32'h0000_8100, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 8'h7F, 1'b0, 8'h7F, 32'h0000_8100, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 32'h0000_8100, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 8'hFE, 1'b0, 8'hFE, 32'h0000_8100, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 8'h00, 1'b1, 8'h00, 32'h00FF_8100, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 8'hFF, 1'b0, 8'hFF, 32'h00FF_8100, 1'b0, 1'b0};
    vt[10] = '{1'b1, 8'h85, 1'b0, 8'h3F, 32'h00FF_8100, 1'b0, 1'b1};
    vt[11] = '{1'b1, 8'hFF, 1'b0, 8'hFF, 32'h00FF_8100, 1'b0, 1'b1};
    vt[12] = '{1'b0, 8'h00, 1'b1, 8'h00, 32'h00FF_8100, 1'b0, 1'b1};

    rst_n = 1'b1;
    do_reset();

    // reset state
    chk("rst_tx_start", 64'(tx_start), 64'd0);
    chk("rst_tx_byte",  64'(tx_byte),  64'd0);
    chk("rst_duty",     64'(duty_out), 64'd0);
    chk("rst_update",   64'(update),   64'd0);
    chk("rst_cmd_err",  64'(cmd_err),  64'd0);
    chk("rst_ovr_err",  64'(ovr_err),  64'd0);

    // table-driven command vectors
    uart_auto = 1'b1;
    for (int i = 0; i < 13; i++) begin
      n = got.size();
      drive1(vt[i].rv, vt[i].rb, vt[i].tick);
      chk($sformatf("vec%0d_duty", i),    64'(duty_out), 64'(vt[i].duty));
      chk($sformatf("vec%0d_update", i),  64'(update),   64'(vt[i].upd));
      chk($sformatf("vec%0d_cmd_err", i), 64'(cmd_err),  64'(vt[i].cerr));
      if (vt[i].rv) begin
        wait_resp(n, r);
        chk($sformatf("vec%0d_resp", i), 64'(r), 64'(vt[i].resp));
      end
      drive1(1'b0, 8'h00, 1'b0);
      chk($sformatf("vec%0d_update_clear", i), 64'(update), 64'd0);
    end

    // commit on tick, repeated ticks, write racing apply
    do_reset();
    send(8'h80, 8'h80, "seqb_sel0");
    send(8'h10, 8'h10, "seqb_wr");
    n = got.size();
    drive1(1'b1, 8'hFE, 1'b1);
    chk("seqb_commit_tick_noupd", 64'(update), 64'd0);
    chk("seqb_commit_tick_duty",  64'(duty_out), 64'd0);
    wait_resp(n, r);
    chk("seqb_commit_resp", 64'(r), 64'hFE);
    drive1(1'b0, 8'h00, 1'b1);
    chk("seqb_next_tick_upd",  64'(update), 64'd1);
    chk("seqb_next_tick_duty", 64'(duty_out), 64'h20);
    drive1(1'b0, 8'h00, 1'b0);
    chk("seqb_upd_one_cycle", 64'(update), 64'd0);
    drive1(1'b0, 8'h00, 1'b1);
    chk("seqb_single_apply", 64'(update), 64'd0);
    send(8'hFE, 8'hFE, "seqb_commit2");
    send(8'hFE, 8'hFE, "seqb_commit3");
    n = got.size();
    drive1(1'b1, 8'h7F, 1'b1);
    chk("seqb_wr_apply_upd",  64'(update), 64'd1);
    chk("seqb_wr_apply_duty", 64'(duty_out), 64'h20);
    wait_resp(n, r);
    drive1(1'b0, 8'h00, 1'b1);
    chk("seqb_repeat_commit_single", 64'(update), 64'd0);
    send(8'hFE, 8'hFE, "seqb_commit4");
    drive1(1'b0, 8'h00, 1'b1);
    chk("seqb_new_shadow_kept", 64'(duty_out), 64'hFF);

    // overrun while transmitter busy
    uart_auto = 1'b0;
    do_reset();
    s0 = starts;
    n  = got.size();
    drive1(1'b1, 8'h80, 1'b0);
    wait_resp(n, r);
    chk("ovr_first_byte", 64'(r), 64'h80);
    man_busy = 1'b1;
    drive1(1'b1, 8'h10, 1'b0);
    chk("ovr_queued_not_overrun", 64'(ovr_err), 64'd0);
    drive1(1'b1, 8'h20, 1'b0);
    chk("ovr_set", 64'(ovr_err), 64'd1);
    repeat (4) drive1(1'b0, 8'h00, 1'b0);
    chk("ovr_no_start_while_busy", 64'(starts - s0), 64'd1);
    chk("ovr_tx_byte_stable", 64'(tx_byte), 64'h80);
    man_busy = 1'b0;
    wait_resp(n + 1, r);
    chk("ovr_second_is_third", 64'(r), 64'h20);
    repeat (8) drive1(1'b0, 8'h00, 1'b0);
    chk("ovr_two_starts", 64'(starts - s0), 64'd2);
    chk("ovr_sticky", 64'(ovr_err), 64'd1);

    // reset asserted mid-transmit with a commit pending
    do_reset();
    send(8'h40, 8'h40, "rstx_wr");
    send(8'hFE, 8'hFE, "rstx_commit");
    send(8'h85, 8'h3F, "rstx_err");
    n = got.size();
    drive1(1'b1, 8'hFF, 1'b0);
    wait_resp(n, r);
    chk("rstx_readback", 64'(r), 64'h00);
    man_busy = 1'b1;
    drive1(1'b0, 8'h00, 1'b0);
    drive1(1'b1, 8'h01, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstx_tx_start", 64'(tx_start), 64'd0);
    chk("rstx_tx_byte",  64'(tx_byte),  64'd0);
    chk("rstx_duty",     64'(duty_out), 64'd0);
    chk("rstx_update",   64'(update),   64'd0);
    chk("rstx_cmd_err",  64'(cmd_err),  64'd0);
    man_busy = 1'b0;
    s0 = starts;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    drive1(1'b0, 8'h00, 1'b1);
    chk("rstx_no_update_after", 64'(update), 64'd0);
    repeat (10) drive1(1'b0, 8'h00, 1'b0);
    chk("rstx_no_start_after", 64'(starts - s0), 64'd0);
    chk("rstx_duty_after",     64'(duty_out), 64'd0);

    // randomized run against the behavioural model
    do_reset();
    uart_auto = 1'b1;
    for (int i = 0; i < NCHAN; i++) begin m_sh[i] = 0; m_act[i] = 0; end
    m_sel = 0; m_pend = 1'b0; m_cerr = 1'b0;
    for (int c = 0; c < 200; c++) begin
      int k;
      int w;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: b = 8'($urandom_range(0, 127));
        4, 5:       b = 8'(128 + $urandom_range(0, NCHAN - 1));
        6:          b = 8'(128 + NCHAN + $urandom_range(0, 125 - NCHAN));
        7:          b = 8'hFE;
        default:    b = 8'hFF;
      endcase
      k = exp_q.size();
      mcycle(1'b1, b, 1'($urandom_range(0, 3) == 0));
      w = 0;
      while (got.size() < exp_q.size() && w < 40) begin
        mcycle(1'b0, 8'h00, 1'($urandom_range(0, 3) == 0));
        w++;
      end
      if (got.size() < exp_q.size()) begin
        chk("rand_resp_timeout", 64'(got.size()), 64'(exp_q.size()));
        break;
      end
      chk($sformatf("rand_resp%0d", k), 64'(got[k]), 64'(exp_q[k]));
      repeat ($urandom_range(0, 2)) mcycle(1'b0, 8'h00, 1'($urandom_range(0, 3) == 0));
    end
    repeat (10) mcycle(1'b0, 8'h00, 1'b0);
    chk("rand_no_overrun", 64'(ovr_err), 64'd0);
    chk("rand_resp_count", 64'(got.size()), 64'(exp_q.size()));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
